// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Holds the state encoding, opcode/funct constants, datapath select encodings
// and the packed control-word struct. The PC-source resolver imports the same constants.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] PCSRC_SEQ  = 2'b00;
    localparam logic [1:0] PCSRC_BEQ  = 2'b01;
    localparam logic [1:0] PCSRC_BNE  = 2'b10;
    localparam logic [1:0] PCSRC_JUMP = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    // Dispatch target out of DECODE; unknown opcodes fall back to FETCH.
    function automatic state_e decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
        state_e s;
        case (op)
            OP_RTYPE:      s = (fn == FUNCT_JR) ? S_JR : S_R_EXEC;
            OP_LW, OP_SW:  s = S_MEM_ADDR;
            OP_BEQ, OP_BNE: s = S_BRANCH;
            OP_J, OP_JAL:  s = S_JUMP;
            OP_ADDI:       s = S_I_EXEC;
            default:       s = S_FETCH;
        endcase
        return s;
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
               (op == OP_JAL) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_control_decode.sv
// Combinational state-to-control-word decoder for the multi-cycle MIPS FSM.
// Ports: i_state (current FSM state), i_opcode (IR[31:26]), i_mem_ready (memory handshake),
//        o_ctrl (all datapath enables/selects). Zero latency; only FETCH looks at i_mem_ready.
module mips_control_decode
    import mips_pkg::*;
(
    input  state_e     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.alu_src_b = ALUB_FOUR;
                // IR load and PC+4 commit only in the cycle the fetch completes.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b  = ALUB_IMMSH2;
                o_ctrl.illegal_op = !op_is_legal(i_opcode);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEM_WR: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = REGDST_RD;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                // beq/bne differ only in opcode bit 0.
                o_ctrl.pc_source     = i_opcode[0] ? PCSRC_BNE : PCSRC_BEQ;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                if (i_opcode == OP_JAL) begin
                    // PC already holds PC+4 from FETCH, so it is the link value.
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.reg_dst    = REGDST_RA;
                    o_ctrl.mem_to_reg = M2R_PC;
                end
            end
            S_I_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUB_IMM;
            end
            S_I_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_JR: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/mem/write-back.
// Ports: clk, reset (sync, active-high), opcode/funct from IR, mem_ready handshake in;
//        memory request, datapath enables/selects, illegal_op pulse and state_dbg out.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    always_ff @(posedge clk) begin
        if (reset) r_state <= state_e'(RESET_STATE);
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   w_next = decode_dispatch(opcode, funct);
            S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            // Write-back, branch, jump, jr and unreachable encodings all return to FETCH.
            default:    w_next = S_FETCH;
        endcase
    end

    mips_control_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Reset blanks every output in the cycle it is sampled, so an abandoned
    // instruction cannot leak a write enable or keep a memory request alive.
    assign w_out     = reset ? '0 : w_ctrl;
    assign state_dbg = reset ? 4'd0 : r_state;

    assign mem_req       = w_out.mem_req;
    assign mem_write     = w_out.mem_write;
    assign ir_write      = w_out.ir_write;
    assign pc_write      = w_out.pc_write;
    assign pc_write_cond = w_out.pc_write_cond;
    assign pc_source     = w_out.pc_source;
    assign i_or_d        = w_out.i_or_d;
    assign alu_src_a     = w_out.alu_src_a;
    assign alu_src_b     = w_out.alu_src_b;
    assign alu_op        = w_out.alu_op;
    assign reg_write     = w_out.reg_write;
    assign reg_dst       = w_out.reg_dst;
    assign mem_to_reg    = w_out.mem_to_reg;
    assign illegal_op    = w_out.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: each cycle's expected output word is pushed
// to a scoreboard queue as stimulus is driven and popped/compared before the next edge.
// Expected state sequences are written out explicitly per instruction.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       illegal_op;
    logic [3:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int step  = 0;
    logic [22:0] sb_q[$];

    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MW = 4, WR = 5, RX = 6, RW = 7;
    localparam int BR = 8, JP = 9, IX = 10, IW = 11, JRS = 12;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDI = 6'b001000, RT = 6'b000000;
    localparam logic [5:0] BAD = 6'b111111;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output word for one cycle, taken directly from the per-state output table.
    function automatic logic [22:0] expect_word(input int st, input logic [5:0] op,
                                                input logic rdy, input logic rst);
        logic       mq, mwr, irw, pcw, pcc, iod, asa, rgw, ill;
        logic [1:0] pcs, asb, aop, rdst, m2r;
        mq = 0; mwr = 0; irw = 0; pcw = 0; pcc = 0; iod = 0; asa = 0; rgw = 0; ill = 0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00; rdst = 2'b00; m2r = 2'b00;
        case (st)
            FE:  begin mq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            DE:  begin asb = 2'b11;
                       ill = !(op inside {RT, LW, SW, BEQ, BNE, J, JAL, ADDI}); end
            MA:  begin asa = 1; asb = 2'b10; end
            MR:  begin mq = 1; iod = 1; end
            MW:  begin rgw = 1; m2r = 2'b01; end
            WR:  begin mq = 1; mwr = 1; iod = 1; end
            RX:  begin asa = 1; aop = 2'b10; end
            RW:  begin rgw = 1; rdst = 2'b01; end
            BR:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = (op == BNE) ? 2'b10 : 2'b01; end
            JP:  begin pcw = 1; pcs = 2'b11;
                       if (op == JAL) begin rgw = 1; rdst = 2'b10; m2r = 2'b10; end end
            IX:  begin asa = 1; asb = 2'b10; end
            IW:  begin rgw = 1; end
            JRS: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        if (rst) return 23'd0;
        return {4'(st), mq, mwr, irw, pcw, pcc, pcs, iod, asa, asb, aop, rgw, rdst, m2r, ill};
    endfunction

    // One clock cycle: drive inputs, push expectation, compare before the rising edge.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input int st);
        logic [22:0] obs, exp_w;
        reset = rst; opcode = op; funct = fn; mem_ready = rdy;
        sb_q.push_back(expect_word(st, op, rdy, rst));
        #2;
        obs = {state_dbg, mem_req, mem_write, ir_write, pc_write, pc_write_cond, pc_source,
               i_or_d, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op};
        if (sb_q.size() == 0) begin
            total++; bad++;
            $error("FAIL step%0d scoreboard empty", step);
        end else begin
            exp_w = sb_q.pop_front();
            total++;
            assert (obs === exp_w) else begin
                bad++;
                $error("FAIL step%0d observed=%h expected=%h", step, obs, exp_w);
            end
        end
        step++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; opcode = LW; funct = 6'd0; mem_ready = 1'b1;
        // Reset held three cycles: all outputs zero.
        repeat (3) cyc(1, LW, 6'd0, 1, FE);
        // lw with two wait cycles in MEM_RD (ready ignored in MEM_ADDR/MEM_WB).
        cyc(0, LW, 6'd0, 1, FE);
        cyc(0, LW, 6'd0, 1, DE);
        cyc(0, LW, 6'd0, 1, MA);
        cyc(0, LW, 6'd0, 0, MR);
        cyc(0, LW, 6'd0, 0, MR);
        cyc(0, LW, 6'd0, 1, MR);
        cyc(0, LW, 6'd0, 1, MW);
        // beq then bne.
        cyc(0, BEQ, 6'd0, 1, FE); cyc(0, BEQ, 6'd0, 0, DE); cyc(0, BEQ, 6'd0, 1, BR);
        cyc(0, BNE, 6'd0, 1, FE); cyc(0, BNE, 6'd0, 1, DE); cyc(0, BNE, 6'd0, 0, BR);
        // jal and j.
        cyc(0, JAL, 6'd0, 1, FE); cyc(0, JAL, 6'd0, 1, DE); cyc(0, JAL, 6'd0, 1, JP);
        cyc(0, J,   6'd0, 1, FE); cyc(0, J,   6'd0, 1, DE); cyc(0, J,   6'd0, 1, JP);
        // Illegal opcode: one DECODE cycle with illegal_op, then straight to FETCH.
        cyc(0, BAD, 6'd0, 1, FE); cyc(0, BAD, 6'd0, 1, DE);
        // R-type add with one fetch wait cycle.
        cyc(0, RT, 6'b100000, 0, FE); cyc(0, RT, 6'b100000, 1, FE);
        cyc(0, RT, 6'b100000, 1, DE); cyc(0, RT, 6'b100000, 1, RX); cyc(0, RT, 6'b100000, 1, RW);
        // jr.
        cyc(0, RT, 6'b001000, 1, FE); cyc(0, RT, 6'b001000, 1, DE); cyc(0, RT, 6'b001000, 1, JRS);
        // addi.
        cyc(0, ADDI, 6'd0, 1, FE); cyc(0, ADDI, 6'd0, 1, DE);
        cyc(0, ADDI, 6'd0, 1, IX); cyc(0, ADDI, 6'd0, 1, IW);
        // sw zero-wait.
        cyc(0, SW, 6'd0, 1, FE); cyc(0, SW, 6'd0, 1, DE);
        cyc(0, SW, 6'd0, 1, MA); cyc(0, SW, 6'd0, 1, WR);
        // sw with waits, then reset during the MEM_WR wait.
        cyc(0, SW, 6'd0, 1, FE); cyc(0, SW, 6'd0, 1, DE); cyc(0, SW, 6'd0, 1, MA);
        cyc(0, SW, 6'd0, 0, WR); cyc(0, SW, 6'd0, 0, WR);
        cyc(1, SW, 6'd0, 0, WR);
        // Resumes at FETCH after the reset edge.
        cyc(0, LW, 6'd0, 1, FE);
        cyc(0, LW, 6'd0, 1, DE);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
